// File: rtl/alu_operand_sequencer.sv
// Collects two operands and an opcode from switches, one debounced load press each,
// and offers the completed operation downstream with a valid/ready handshake.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-low reset
//   sw        - raw operand switches (N bits), sampled on a load press
//   op_sw     - raw opcode switches (OPW bits), sampled on a load press
//   btn_load  - raw load push-button, active-high
//   btn_clear - raw clear push-button, active-high
//   op_ready  - downstream accepts the offered operation
//   a, b      - registered operands
//   opcode    - registered opcode
//   op_valid  - operation complete and offered (high exactly in S_ISSUE)
//   phase     - state encoding: 0 S_A, 1 S_B, 2 S_OP, 3 S_ISSUE
//   op_count  - accepted operations, modulo 256
module alu_operand_sequencer #(
   parameter int N   = 4,
   parameter int OPW = 2,
   parameter int DEB = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   sw,
   input  logic [OPW-1:0] op_sw,
   input  logic           btn_load,
   input  logic           btn_clear,
   input  logic           op_ready,
   output logic [N-1:0]   a,
   output logic [N-1:0]   b,
   output logic [OPW-1:0] opcode,
   output logic           op_valid,
   output logic [1:0]     phase,
   output logic [7:0]     op_count
);

   localparam logic [1:0] S_A     = 2'd0;
   localparam logic [1:0] S_B     = 2'd1;
   localparam logic [1:0] S_OP    = 2'd2;
   localparam logic [1:0] S_ISSUE = 2'd3;

   // Stability counter only needs to reach DEB-1.
   localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEB - 1);

   // Bit 0: load button, bit 1: clear button.
   logic [1:0]    raw;
   logic [1:0]    s1;
   logic [1:0]    s2;
   logic [1:0]    deb;
   logic [1:0]    deb_q;
   logic [1:0]    press;
   logic [CW-1:0] cnt [2];

   logic       load_p;
   logic       clear_p;
   logic [1:0] state;

   assign raw = {btn_clear, btn_load};

   // Two-flop synchroniser, then a level that only follows s2 after
   // it has disagreed for DEB consecutive cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= '0;
         s2    <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1    <= raw;
         s2    <= s1;
         deb_q <= deb;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
               deb[i] <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign press   = deb & ~deb_q;
   assign load_p  = press[0];
   assign clear_p = press[1];

   // Clear outranks both a coincident load and a coincident handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_A;
         a        <= '0;
         b        <= '0;
         opcode   <= '0;
         op_count <= '0;
      end else if (clear_p) begin
         state  <= S_A;
         a      <= '0;
         b      <= '0;
         opcode <= '0;
      end else begin
         case (state)
            S_A: begin
               if (load_p) begin
                  a     <= sw;
                  state <= S_B;
               end
            end
            S_B: begin
               if (load_p) begin
                  b     <= sw;
                  state <= S_OP;
               end
            end
            S_OP: begin
               if (load_p) begin
                  opcode <= op_sw;
                  state  <= S_ISSUE;
               end
            end
            default: begin
               if (op_ready) begin
                  op_count <= op_count + 8'd1;
                  state    <= S_A;
               end
            end
         endcase
      end
   end

   assign op_valid = (state == S_ISSUE);
   assign phase    = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: table-driven operations with a queue
// of expected results, plus hand-written debounce, clear and reset sequences.
module tb_alu_operand_sequencer;

   localparam int N   = 4;
   localparam int OPW = 2;
   localparam int DEB = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   sw = '0;
   logic [OPW-1:0] op_sw = '0;
   logic           btn_load = 1'b0;
   logic           btn_clear = 1'b0;
   logic           op_ready = 1'b0;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic [OPW-1:0] opcode;
   logic           op_valid;
   logic [1:0]     phase;
   logic [7:0]     op_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0]   sa;
      logic [N-1:0]   sb;
      logic [OPW-1:0] op;
      logic [N-1:0]   ea;
      logic [N-1:0]   eb;
      logic [OPW-1:0] eop;
   } vec_t;

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic [OPW-1:0] op;
      logic [7:0]     cnt;
   } exp_t;

   vec_t       vt [4];
   exp_t       sb_q [$];
   exp_t       e;
   logic [7:0] cnt_m = '0;

   alu_operand_sequencer #(
      .N(N),
      .OPW(OPW),
      .DEB(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw(sw),
      .op_sw(op_sw),
      .btn_load(btn_load),
      .btn_clear(btn_clear),
      .op_ready(op_ready),
      .a(a),
      .b(b),
      .opcode(opcode),
      .op_valid(op_valid),
      .phase(phase),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic press(input logic ld, input logic cl);
      btn_load  = ld;
      btn_clear = cl;
      repeat (DEB + 4) tick();
      btn_load  = 1'b0;
      btn_clear = 1'b0;
      repeat (DEB + 4) tick();
   endtask

   task automatic do_reset();
      op_ready  = 1'b0;
      btn_load  = 1'b0;
      btn_clear = 1'b0;
      #2 rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      cnt_m = '0;
   endtask

   task automatic load3(input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [OPW-1:0] vo);
      sw = va;
      press(1'b1, 1'b0);
      chk("phase_after_a", phase, 1);
      sw = vb;
      press(1'b1, 1'b0);
      chk("phase_after_b", phase, 2);
      op_sw = vo;
      press(1'b1, 1'b0);
      chk("phase_after_op", phase, 3);
   endtask

   initial begin
      int  k;
      bit  ok;

      vt[0] = '{4'd5,  4'd9,  2'd2, 4'd5,  4'd9,  2'd2};
      vt[1] = '{4'd15, 4'd0,  2'd3, 4'd15, 4'd0,  2'd3};
      vt[2] = '{4'd10, 4'd6,  2'd1, 4'd10, 4'd6,  2'd1};
      vt[3] = '{4'd0,  4'd15, 2'd0, 4'd0,  4'd15, 2'd0};

      // Reset state
      #2 rst = 1'b0;
      #1;
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      chk("rst_opcode", opcode, 0);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_phase", phase, 0);
      chk("rst_op_count", op_count, 0);
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // Table-driven operations
      for (int i = 0; i < 4; i++) begin
         e.a   = vt[i].ea;
         e.b   = vt[i].eb;
         e.op  = vt[i].eop;
         e.cnt = cnt_m + 8'd1;
         sb_q.push_back(e);
         load3(vt[i].sa, vt[i].sb, vt[i].op);
         chk("vec_a", a, vt[i].ea);
         chk("vec_b", b, vt[i].eb);
         chk("vec_opcode", opcode, vt[i].eop);
         chk("vec_op_valid", op_valid, 1);
         op_ready = 1'b1;
         tick();
         op_ready = 1'b0;
         cnt_m++;
         e = sb_q.pop_front();
         chk("xfer_op_count", op_count, e.cnt);
         chk("xfer_op_valid", op_valid, 0);
         chk("xfer_phase", phase, 0);
         chk("retain_a", a, e.a);
         chk("retain_b", b, e.b);
         chk("retain_opcode", opcode, e.op);
      end

      // Bouncing load button, then a clean hold
      ok = 1'b1;
      sw = 4'd7;
      for (int i = 0; i < 5; i++) begin
         btn_load = 1'b1;
         tick();
         tick();
         if (phase != 2'd0) ok = 1'b0;
         btn_load = 1'b0;
         tick();
         tick();
         if (phase != 2'd0) ok = 1'b0;
      end
      chk("bounce_no_pulse", ok, 1);
      btn_load = 1'b1;
      k = 0;
      while (phase == 2'd0 && k < 40) begin
         tick();
         k++;
      end
      chk("bounce_latency", k, DEB + 3);
      repeat (30) tick();
      chk("held_single_pulse", phase, 1);
      chk("held_a", a, 7);
      btn_load = 1'b0;
      repeat (DEB + 4) tick();
      press(1'b0, 1'b1);
      chk("clear_phase", phase, 0);
      chk("clear_a", a, 0);

      // Stall in S_ISSUE with extra load presses
      load3(4'd3, 4'd12, 2'd1);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         btn_load = 1'b1;
         repeat (DEB + 4) begin
            tick();
            if (!op_valid || a != 4'd3 || b != 4'd12 || opcode != 2'd1)
               ok = 1'b0;
         end
         btn_load = 1'b0;
         repeat (DEB + 4) begin
            tick();
            if (!op_valid || a != 4'd3 || b != 4'd12 || opcode != 2'd1)
               ok = 1'b0;
         end
      end
      chk("stall_stable", ok, 1);
      chk("stall_op_count", op_count, cnt_m);
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      cnt_m++;
      chk("stall_release_count", op_count, cnt_m);

      // Clear and load pulses in the same cycle while in S_OP
      sw = 4'd7;
      press(1'b1, 1'b0);
      sw = 4'd4;
      press(1'b1, 1'b0);
      chk("sop_phase", phase, 2);
      op_sw = 2'd3;
      ok = 1'b1;
      btn_load  = 1'b1;
      btn_clear = 1'b1;
      repeat (DEB + 4) begin
         tick();
         if (op_valid) ok = 1'b0;
      end
      btn_load  = 1'b0;
      btn_clear = 1'b0;
      repeat (DEB + 4) begin
         tick();
         if (op_valid) ok = 1'b0;
      end
      chk("clr_ld_no_valid", ok, 1);
      chk("clr_ld_a", a, 0);
      chk("clr_ld_b", b, 0);
      chk("clr_ld_opcode", opcode, 0);
      chk("clr_ld_phase", phase, 0);

      // Clear pulse coinciding with op_ready in S_ISSUE
      load3(4'd2, 4'd3, 2'd1);
      btn_clear = 1'b1;
      repeat (DEB + 2) tick();
      op_ready = 1'b1;
      tick();
      op_ready  = 1'b0;
      btn_clear = 1'b0;
      chk("clr_rdy_count", op_count, cnt_m);
      chk("clr_rdy_phase", phase, 0);
      chk("clr_rdy_a", a, 0);
      repeat (DEB + 4) tick();

      // 256 back-to-back operations with op_ready held high
      do_reset();
      op_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         e.a   = 4'(i);
         e.b   = 4'(i >> 4);
         e.op  = 2'(i);
         e.cnt = cnt_m + 8'd1;
         sb_q.push_back(e);
         sw = 4'(i);
         press(1'b1, 1'b0);
         sw = 4'(i >> 4);
         press(1'b1, 1'b0);
         op_sw = 2'(i);
         press(1'b1, 1'b0);
         cnt_m++;
         e = sb_q.pop_front();
         if (i == 0 || i == 127 || i == 254 || i == 255) begin
            chk("b2b_op_count", op_count, e.cnt);
            chk("b2b_opcode", opcode, e.op);
         end
      end
      op_ready = 1'b0;
      chk("wrap_op_count", op_count, 0);

      // Asynchronous reset while op_valid is high
      load3(4'd9, 4'd10, 2'd3);
      chk("pre_rst_valid", op_valid, 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("async_a", a, 0);
      chk("async_b", b, 0);
      chk("async_opcode", opcode, 0);
      chk("async_op_valid", op_valid, 0);
      chk("async_phase", phase, 0);
      chk("async_op_count", op_count, 0);
      btn_load = 1'b1;
      sw = 4'd6;
      repeat (3) tick();
      @(negedge clk);
      rst = 1'b1;
      k = 0;
      while (phase == 2'd0 && k < 40) begin
         tick();
         k++;
      end
      chk("held_at_release_latency", k, DEB + 3);
      btn_load = 1'b0;
      repeat (DEB + 4) tick();
      chk("post_rst_a", a, 6);
      chk("post_rst_valid1", op_valid, 0);
      sw = 4'd1;
      press(1'b1, 1'b0);
      chk("post_rst_valid2", op_valid, 0);
      op_sw = 2'd2;
      press(1'b1, 1'b0);
      chk("post_rst_valid3", op_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits.
REQ-002 SHALL have parameter OPW, default 2, opcode width in bits.
REQ-003 SHALL have parameter DEB, default 4, debounce stability window in clock cycles (DEB >= 1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sw  input  N  raw operand switches, sampled only on a load event.
REQ-007 SHALL have port op_sw  input  OPW  raw opcode switches, sampled only on a load event.
REQ-008 SHALL have port btn_load  input  1  raw asynchronous load push-button, active-high.
REQ-009 SHALL have port btn_clear  input  1  raw asynchronous clear push-button, active-high.
REQ-010 SHALL have port op_ready  input  1  downstream ALU/register stage accepts the operation.
REQ-011 SHALL have port a  output  N  registered operand A.
REQ-012 SHALL have port b  output  N  registered operand B.
REQ-013 SHALL have port opcode  output  OPW  registered opcode.
REQ-014 SHALL have port op_valid  output  1  operation {a,b,opcode} complete and offered downstream.
REQ-015 SHALL have port phase  output  2  current state encoding: 0 S_A, 1 S_B, 2 S_OP, 3 S_ISSUE.
REQ-016 SHALL have port op_count  output  8  number of accepted operations, modulo 256.

Function
REQ-017 SHALL pass btn_load and btn_clear each through a 2-flop synchroniser before any other use.
REQ-018 SHALL debounce each synchronised button: debounced level adopts the synchronised level only after that level has differed from it for DEB consecutive cycles; any bounce restarts the count.
REQ-019 SHALL generate a one-cycle press pulse on each debounced 0->1 transition; a clean press held high produces its pulse exactly DEB+2 rising edges after the first edge sampling btn_load high.
REQ-020 SHALL generate no further pulse while a button stays held; a new pulse requires a debounced release then press.
REQ-021 SHALL implement FSM S_A -> S_B -> S_OP -> S_ISSUE -> S_A.
REQ-022 In S_A, a load pulse SHALL capture sw into a and move to S_B.
REQ-023 In S_B, a load pulse SHALL capture sw into b and move to S_OP.
REQ-024 In S_OP, a load pulse SHALL capture op_sw into opcode and move to S_ISSUE; op_valid asserts in the following cycle.
REQ-025 op_valid SHALL be 1 exactly while in S_ISSUE; a, b, opcode SHALL remain stable while op_valid is 1.
REQ-026 In S_ISSUE, op_valid=1 and op_ready=1 at a rising edge SHALL complete a transfer: op_count increments (255 wraps to 0), FSM returns to S_A, op_valid low next cycle.
REQ-027 In S_ISSUE, load pulses SHALL be ignored; op_valid SHALL be held indefinitely until op_ready.
REQ-028 a, b, opcode SHALL retain their last values after a transfer until overwritten by the next load in the corresponding state.
REQ-029 A clear pulse SHALL, in any state, zero a, b, opcode, force S_A, and drop op_valid next cycle; op_count is not affected.
REQ-030 Clear pulse and load pulse in the same cycle: clear SHALL win; the load is discarded.
REQ-031 Clear pulse coinciding with op_ready in S_ISSUE: clear SHALL win; no transfer counted.
REQ-032 op_ready while not in S_ISSUE SHALL have no effect.

Reset
REQ-033 rst=0 SHALL asynchronously force a=0, b=0, opcode=0, op_valid=0, phase=0 (S_A), op_count=0, synchroniser, debounce and edge state to 0.
REQ-034 Reset asserted mid-sequence or mid-debounce SHALL abandon it; after release the block waits in S_A, and a button already held high at release yields one press pulse after DEB+2 edges.

Verification (N=4, OPW=2, DEB=4)
REQ-035 Reset, then loads with sw=5, sw=9, op_sw=2 -> a=5, b=9, opcode=2, phase=3, op_valid=1; op_ready=1 one cycle -> op_valid=0, phase=0, op_count=1.
REQ-036 btn_load toggling every 2 cycles for 20 cycles then held high -> exactly one load pulse, issued DEB+2 edges after the final rise.
REQ-037 Full operation with op_ready=0 for 50 cycles plus 3 extra load presses -> op_valid stays 1, a/b/opcode unchanged, op_count unchanged.
REQ-038 In S_OP, clear and load debounced into the same cycle -> a=b=opcode=0, phase=0, op_valid never asserts.
REQ-039 256 back-to-back accepted operations -> op_count returns to 0.
REQ-040 rst=0 asynchronously while op_valid=1 -> all outputs 0 before next clk edge; after release no op_valid without three new loads.
